// File: rtl/tmds_encoder_dvi_pkg.sv
// tmds_pkg: shared constants, types and helpers for the DVI TMDS channel encoder.
//   TMDS_CTRL_xx  : the four 10-bit control-period symbols, indexed by {c1,c0}
//   TMDS_BIAS_W   : width of the signed running-disparity (bias) register
//   tmds_stage1_t : stage-1 pipeline word (de, ctrl, transition-minimised q_m)
//   popcount8     : number of ones in a byte
//   ctrl_symbol   : control symbol for a given {c1,c0}
package tmds_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  localparam int unsigned TMDS_BIAS_W = 5;

  typedef struct packed {
    logic       de;
    logic [1:0] ctrl;
    logic [8:0] q_m;
  } tmds_stage1_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
    logic [9:0] s;
    unique case (c)
      2'b00:   s = TMDS_CTRL_00;
      2'b01:   s = TMDS_CTRL_01;
      2'b10:   s = TMDS_CTRL_10;
      default: s = TMDS_CTRL_11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tmds_encoder_dvi_if.sv
// tmds_encoder_dvi_if: pixel-side bundle of one TMDS channel encoder.
//   i_data  [7:0] pixel component, meaningful when i_de=1
//   i_ctrl  [1:0] control bits {c1,c0}, meaningful when i_de=0
//   i_de          1 = video data period, 0 = control period
//   o_tmds  [9:0] encoded symbol, bit 0 transmitted first
// master drives the pixel side, slave is the encoder.
interface tmds_encoder_dvi_if;

  logic [7:0] i_data;
  logic [1:0] i_ctrl;
  logic       i_de;
  logic [9:0] o_tmds;

  modport master (output i_data, output i_ctrl, output i_de, input o_tmds);
  modport slave  (input i_data, input i_ctrl, input i_de, output o_tmds);

endinterface

// File: rtl/tmds_encoder_dvi.sv
// tmds_encoder_dvi: DVI/TMDS 8b/10b channel encoder, one symbol per pixel clock.
//   i_clk   : pixel (parallel) clock, shared with serializer_10to1
//   i_rst_n : asynchronous active-low reset
//   bus     : tmds_encoder_dvi_if.slave (i_data, i_ctrl, i_de in; o_tmds out)
// Pipeline: optional input register (REG_INPUT=1), stage 1 transition
// minimisation, stage 2 DC balance + output register. de/ctrl travel with
// the data so they stay aligned. Latency 2 (REG_INPUT=0) or 3 cycles.
module tmds_encoder_dvi
  import tmds_pkg::*;
#(
  parameter int unsigned REG_INPUT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  tmds_encoder_dvi_if.slave  bus
);

  localparam logic signed [TMDS_BIAS_W-1:0] BIAS_ZERO = '0;
  localparam logic signed [TMDS_BIAS_W-1:0] BIAS_TWO  = TMDS_BIAS_W'(2);

  // ---------------- optional input register ----------------
  logic [7:0] in_data;
  logic [1:0] in_ctrl;
  logic       in_de;

  generate
    if (REG_INPUT != 0) begin : g_in_reg
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          in_data <= '0;
          in_ctrl <= '0;
          in_de   <= 1'b0;
        end else begin
          in_data <= bus.i_data;
          in_ctrl <= bus.i_ctrl;
          in_de   <= bus.i_de;
        end
      end
    end else begin : g_in_comb
      assign in_data = bus.i_data;
      assign in_ctrl = bus.i_ctrl;
      assign in_de   = bus.i_de;
    end
  endgenerate

  // ---------------- stage 1: transition minimisation ----------------
  logic [3:0]   n1_d;
  logic         use_xnor;
  logic [8:0]   q_m;
  tmds_stage1_t s1;

  always_comb begin
    n1_d     = popcount8(in_data);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !in_data[0]);
    q_m      = '0;
    q_m[0]   = in_data[0];
    for (int unsigned i = 1; i < 8; i++) begin
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ in_data[i]) : (q_m[i-1] ^ in_data[i]);
    end
    q_m[8] = ~use_xnor;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= '0;
    end else begin
      s1.de   <= in_de;
      s1.ctrl <= in_ctrl;
      s1.q_m  <= q_m;
    end
  end

  // ---------------- stage 2: DC balance ----------------
  // bias equals the running ones-minus-zeros of the emitted 10-bit symbols
  // since the last control period, so it is cleared whenever de=0 here.
  logic                          q8;
  logic [7:0]                    q;
  logic [3:0]                    n1_q;
  logic [3:0]                    n0_q;
  logic signed [TMDS_BIAS_W-1:0] diff;
  logic signed [TMDS_BIAS_W-1:0] bias;
  logic signed [TMDS_BIAS_W-1:0] bias_nxt;
  logic [9:0]                    sym_nxt;

  always_comb begin
    q8       = s1.q_m[8];
    q        = s1.q_m[7:0];
    n1_q     = popcount8(q);
    n0_q     = 4'd8 - n1_q;
    diff     = $signed({1'b0, n1_q}) - $signed({1'b0, n0_q});
    sym_nxt  = TMDS_CTRL_00;
    bias_nxt = bias;
    if (!s1.de) begin
      sym_nxt  = ctrl_symbol(s1.ctrl);
      bias_nxt = BIAS_ZERO;
    end else if ((bias == BIAS_ZERO) || (n1_q == n0_q)) begin
      sym_nxt  = {~q8, q8, (q8 ? q : ~q)};
      bias_nxt = q8 ? (bias + diff) : (bias - diff);
    end else if (((bias > BIAS_ZERO) && (n1_q > n0_q)) ||
                 ((bias < BIAS_ZERO) && (n0_q > n1_q))) begin
      sym_nxt  = {1'b1, q8, ~q};
      bias_nxt = bias + (q8 ? BIAS_TWO : BIAS_ZERO) - diff;
    end else begin
      sym_nxt  = {1'b0, q8, q};
      bias_nxt = bias + diff - (q8 ? BIAS_ZERO : BIAS_TWO);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bias       <= BIAS_ZERO;
      bus.o_tmds <= TMDS_CTRL_00;
    end else begin
      bias       <= bias_nxt;
      bus.o_tmds <= sym_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Self-checking bench for tmds_encoder_dvi: directed vectors with literal
// expectations plus a behavioural reference model compared every cycle.
module tb_tmds_encoder_dvi;

  localparam int unsigned REG_IN = 1;
  localparam int S = 2 + int'(REG_IN);

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  tmds_encoder_dvi_if bus();

  tmds_encoder_dvi #(.REG_INPUT(REG_IN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [9:0] sym;
    int         cnt;
  } enc_t;

  typedef struct packed {
    logic       de;
    logic [7:0] data;
    logic [9:0] sym;
  } exp_t;

  // Encode one input given the running disparity of what has been sent.
  function automatic enc_t model_enc(input logic de, input logic [1:0] c,
                                     input logic [7:0] d, input int cnt);
    enc_t r;
    int n1d, n1;
    logic xn;
    logic [8:0] qm;
    r.sym = 10'h000;
    r.cnt = 0;
    if (!de) begin
      case (c)
        2'b00:   r.sym = 10'h354;
        2'b01:   r.sym = 10'h0AB;
        2'b10:   r.sym = 10'h154;
        default: r.sym = 10'h2AB;
      endcase
      return r;
    end
    n1d = $countones(d);
    xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm = 9'h000;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1 = $countones(qm[7:0]);
    if (cnt == 0 || n1 == 4)
      r.sym = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
    else if ((cnt > 0 && n1 > 4) || (cnt < 0 && n1 < 4))
      r.sym = {1'b1, qm[8], ~qm[7:0]};
    else
      r.sym = {1'b0, qm[8], qm[7:0]};
    r.cnt = cnt + 2 * $countones(r.sym) - 10;
    return r;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] qv, dv;
    qv = s[9] ? ~s[7:0] : s[7:0];
    dv = 8'h00;
    dv[0] = qv[0];
    for (int i = 1; i < 8; i++) dv[i] = s[8] ? (qv[i] ^ qv[i-1]) : ~(qv[i] ^ qv[i-1]);
    return dv;
  endfunction

  int   m_cnt;
  enc_t m_next;
  exp_t pipe [S];

  always_comb m_next = model_enc(bus.i_de, bus.i_ctrl, bus.i_data, m_cnt);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      for (int i = 0; i < S; i++) pipe[i] <= '{de: 1'b0, data: 8'h00, sym: 10'h354};
    end else begin
      m_cnt <= m_next.cnt;
      for (int i = 1; i < S; i++) pipe[i] <= pipe[i-1];
      pipe[0] <= '{de: bus.i_de, data: bus.i_data, sym: m_next.sym};
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  int run_disp = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_sym", bus.o_tmds, pipe[S-1].sym);
      if (!rst_n || !pipe[S-1].de) begin
        run_disp = 0;
      end else begin
        check_int("decode", int'(decode(bus.o_tmds)), int'(pipe[S-1].data));
        run_disp = run_disp + 2 * $countones(bus.o_tmds) - 10;
        check_int("disparity_bound", int'(run_disp <= 10 && run_disp >= -10), 1);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic       vde   [16];
  logic [1:0] vctrl [16];
  logic [7:0] vdata [16];
  logic [9:0] vexp  [16];

  task automatic drive(input logic de, input logic [1:0] c, input logic [7:0] d);
    bus.i_de   = de;
    bus.i_ctrl = c;
    bus.i_data = d;
  endtask

  task automatic set_vec(input int i, input logic de, input logic [1:0] c,
                         input logic [7:0] d, input logic [9:0] e);
    vde[i] = de; vctrl[i] = c; vdata[i] = d; vexp[i] = e;
  endtask

  // Drive n vectors back to back; each expected symbol is checked once it
  // has travelled the pipeline. Trailing inputs are ctrl-00 control cycles.
  task automatic play(input int n, input string name);
    for (int i = 0; i < n + S - 1; i++) begin
      if (i < n) drive(vde[i], vctrl[i], vdata[i]);
      else       drive(1'b0, 2'b00, 8'h00);
      @(posedge clk); #1;
      if (i >= S - 1)
        check($sformatf("%s[%0d]", name, i - S + 1), bus.o_tmds, vexp[i - S + 1]);
    end
  endtask

  enc_t pin;

  initial begin
    drive(1'b0, 2'b00, 8'h00);

    // Pin the model itself against hand-computed symbols.
    pin = model_enc(1'b1, 2'b00, 8'h00, 0);
    check("pin_00_a", pin.sym, 10'h100); check_int("pin_00_a_cnt", pin.cnt, -8);
    pin = model_enc(1'b1, 2'b00, 8'h00, pin.cnt);
    check("pin_00_b", pin.sym, 10'h3FF); check_int("pin_00_b_cnt", pin.cnt, 2);
    pin = model_enc(1'b1, 2'b00, 8'h00, pin.cnt);
    check("pin_00_c", pin.sym, 10'h100); check_int("pin_00_c_cnt", pin.cnt, -6);
    pin = model_enc(1'b1, 2'b00, 8'hFF, 0);
    check("pin_ff", pin.sym, 10'h200);

    // Reset held: inputs toggle, output stays on the ctrl-00 symbol.
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'(i), 2'($urandom), 8'($urandom));
      @(posedge clk); #1;
      check("reset_hold", bus.o_tmds, 10'h354);
    end
    drive(1'b0, 2'b00, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < S + 2; i++) begin
      @(posedge clk); #1;
      check("reset_release", bus.o_tmds, 10'h354);
    end

    // Control symbols in order.
    set_vec(0, 1'b0, 2'b01, 8'h00, 10'h0AB);
    set_vec(1, 1'b0, 2'b10, 8'h00, 10'h154);
    set_vec(2, 1'b0, 2'b11, 8'h00, 10'h2AB);
    play(3, "ctrl");

    // DC balance from bias 0 with an all-zero byte.
    set_vec(0, 1'b1, 2'b00, 8'h00, 10'h100);
    set_vec(1, 1'b1, 2'b00, 8'h00, 10'h3FF);
    set_vec(2, 1'b1, 2'b00, 8'h00, 10'h100);
    play(3, "balance");

    // de toggling every cycle: bias restarts at 0 after each control cycle.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) set_vec(i, 1'b1, 2'b11, 8'hFF, 10'h200);
      else            set_vec(i, 1'b0, 2'b11, 8'hFF, 10'h2AB);
    end
    play(8, "de_toggle");

    // Long random data burst, checked by the per-cycle compare.
    for (int i = 0; i < 10000; i++) begin
      drive(1'b1, 2'($urandom), 8'($urandom));
      @(posedge clk); #1;
    end

    // Asynchronous reset between clock edges in the middle of a burst.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b00, 8'($urandom));
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 check("async_reset", bus.o_tmds, 10'h354);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("async_reset_hold", bus.o_tmds, 10'h354);
    set_vec(0, 1'b1, 2'b00, 8'h00, 10'h100);
    set_vec(1, 1'b1, 2'b00, 8'h00, 10'h3FF);
    set_vec(2, 1'b1, 2'b00, 8'h00, 10'h100);
    rst_n = 1'b1;
    play(3, "post_reset");

    // A few more random mixed cycles after reset.
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom));
      @(posedge clk); #1;
    end

    drive(1'b0, 2'b00, 8'h00);
    repeat (S + 1) begin
      @(posedge clk); #1;
    end
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
